// File: rtl/mem_bus_ctrl.sv
// Memory bus sequencer for the 5-stage core: I/D handshakes with active-low acks,
// global pipeline freeze, per-side timeout with sticky error and a freeze-cycle counter.
module mem_bus_ctrl #(
  parameter int TIMEOUT = 8,
  parameter int CW      = 4,
  parameter int SW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic          mem_req,
  input  logic          mem_wr,
  input  logic          ACKI_n,
  input  logic          ACKD_n,
  input  logic          err_clr,
  output logic          MREQ,
  output logic          WRITE,
  output logic          freeze,
  output logic          inst_valid,
  output logic          data_done,
  output logic          bus_err,
  output logic [1:0]    err_src,
  output logic [SW-1:0] stall_cnt
);

  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic          i_done, d_done;
  logic [CW-1:0] i_cnt, d_cnt;
  logic          pend_i, pend_d;
  logic          ack_i, ack_d;
  logic          to_i, to_d;
  logic          ok_i, ok_d;

  always_comb begin
    pend_i = if_req & ~i_done;
    pend_d = mem_req & ~d_done;
    ack_i  = pend_i & ~ACKI_n;
    ack_d  = pend_d & ~ACKD_n;
    to_i   = pend_i & ACKI_n & (i_cnt == LAST);
    to_d   = pend_d & ACKD_n & (d_cnt == LAST);
    ok_i   = ~if_req | i_done | ack_i | to_i;
    ok_d   = ~mem_req | d_done | ack_d | to_d;
  end

  // Outputs are gated with rst so they drop the instant reset is asserted.
  always_comb begin
    freeze     = rst & ~(ok_i & ok_d);
    MREQ       = mem_req & ~d_done & rst;
    WRITE      = MREQ & mem_wr;
    inst_valid = rst & if_req & (ack_i | (i_done & ~freeze));
    data_done  = rst & ~freeze & mem_req;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_done    <= 1'b0;
      d_done    <= 1'b0;
      i_cnt     <= '0;
      d_cnt     <= '0;
      bus_err   <= 1'b0;
      err_src   <= '0;
      stall_cnt <= '0;
    end else begin
      if (!freeze) begin
        i_done <= 1'b0;
        d_done <= 1'b0;
      end else begin
        if (ack_i | to_i) i_done <= 1'b1;
        if (ack_d | to_d) d_done <= 1'b1;
      end

      if (ack_i | to_i | ~freeze | ~if_req) i_cnt <= '0;
      else if (pend_i & ACKI_n)             i_cnt <= i_cnt + CW'(1);

      if (ack_d | to_d | ~freeze | ~mem_req) d_cnt <= '0;
      else if (pend_d & ACKD_n)              d_cnt <= d_cnt + CW'(1);

      // A timeout coinciding with err_clr leaves the flag set.
      if (to_i | to_d)  bus_err <= 1'b1;
      else if (err_clr) bus_err <= 1'b0;
      err_src <= (err_clr ? 2'b00 : err_src) | {to_d, to_i};

      if (freeze && stall_cnt != '1) stall_cnt <= stall_cnt + SW'(1);
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Scoreboard bench for mem_bus_ctrl: directed scenarios then randomized traffic,
// expected outputs from a transaction-level reference model.
module tb_mem_bus_ctrl;
  localparam int TIMEOUT = 8;
  localparam int CW      = 4;
  localparam int SW      = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          if_req = 1'b0, mem_req = 1'b0, mem_wr = 1'b0;
  logic          acki_n = 1'b1, ackd_n = 1'b1, err_clr = 1'b0;
  logic          mreq, write, freeze, inst_valid, data_done, bus_err;
  logic [1:0]    err_src;
  logic [SW-1:0] stall_cnt;

  mem_bus_ctrl #(.TIMEOUT(TIMEOUT), .CW(CW), .SW(SW)) dut (
    .clk(clk), .rst(rst), .if_req(if_req), .mem_req(mem_req), .mem_wr(mem_wr),
    .ACKI_n(acki_n), .ACKD_n(ackd_n), .err_clr(err_clr),
    .MREQ(mreq), .WRITE(write), .freeze(freeze), .inst_valid(inst_valid),
    .data_done(data_done), .bus_err(bus_err), .err_src(err_src), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          mreq, write, freeze, inst_valid, data_done, bus_err;
    logic [1:0]    err_src;
    logic [SW-1:0] stall;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: per-side "finished" flag and "cycles waited" for the current access.
  bit       m_ifin, m_dfin, m_berr, m_frz_prev;
  int       m_iwait, m_dwait, m_stall;
  bit [1:0] m_esrc;
  bit       prev_if, prev_mem, prev_wr;

  task automatic cyc(input bit r, input bit ir, input bit mr, input bit mw,
                     input bit ai, input bit ad, input bit ec);
    exp_t e;
    bit i_now, i_to, d_now, d_to, frz;
    @(posedge clk); #1;
    if (r && m_frz_prev)
      assert (ir == prev_if && mr == prev_mem && mw == prev_wr)
        else $error("request inputs changed while frozen");
    rst = r; if_req = ir; mem_req = mr; mem_wr = mw;
    acki_n = ai; ackd_n = ad; err_clr = ec;
    frz = 1'b0;
    e = '{default: '0};
    if (!r) begin
      m_ifin = 0; m_dfin = 0; m_iwait = 0; m_dwait = 0;
      m_berr = 0; m_esrc = 0; m_stall = 0;
    end else begin
      i_now = ir && !m_ifin && !ai;
      d_now = mr && !m_dfin && !ad;
      i_to  = ir && !m_ifin && ai && (m_iwait == TIMEOUT - 1);
      d_to  = mr && !m_dfin && ad && (m_dwait == TIMEOUT - 1);
      frz   = !((!ir || m_ifin || i_now || i_to) && (!mr || m_dfin || d_now || d_to));
      e.mreq       = mr && !m_dfin;
      e.write      = mr && !m_dfin && mw;
      e.freeze     = frz;
      e.inst_valid = ir && (i_now || (!frz && m_ifin));
      e.data_done  = !frz && mr;
      e.bus_err    = m_berr;
      e.err_src    = m_esrc;
      e.stall      = m_stall[SW-1:0];
      m_iwait = (ir && !m_ifin && ai && !i_to) ? m_iwait + 1 : 0;
      m_dwait = (mr && !m_dfin && ad && !d_to) ? m_dwait + 1 : 0;
      m_ifin  = frz && (m_ifin || i_now || i_to);
      m_dfin  = frz && (m_dfin || d_now || d_to);
      if (ec) m_esrc = 2'b00;
      m_esrc = m_esrc | {d_to, i_to};
      if (i_to || d_to) m_berr = 1;
      else if (ec)      m_berr = 0;
      if (frz && m_stall < (1 << SW) - 1) m_stall++;
    end
    m_frz_prev = frz; prev_if = ir; prev_mem = mr; prev_wr = mw;
    q.push_back(e);
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", n, $time, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("MREQ",       32'(mreq),       32'(e.mreq));
        chk("WRITE",      32'(write),      32'(e.write));
        chk("freeze",     32'(freeze),     32'(e.freeze));
        chk("inst_valid", 32'(inst_valid), 32'(e.inst_valid));
        chk("data_done",  32'(data_done),  32'(e.data_done));
        chk("bus_err",    32'(bus_err),    32'(e.bus_err));
        chk("err_src",    32'(err_src),    32'(e.err_src));
        chk("stall_cnt",  32'(stall_cnt),  32'(e.stall));
      end
    end
  end

  initial begin : stim
    int ack_pct;
    bit ir, mr, mw;
    cyc(0, 0, 0, 0, 1, 1, 0);
    cyc(0, 0, 0, 0, 1, 1, 0);
    // zero-wait
    cyc(1, 1, 1, 0, 0, 0, 0);
    // I-side wait of three cycles
    cyc(0, 0, 0, 0, 1, 1, 0);
    for (int c = 0; c < 4; c++) cyc(1, 1, 0, 0, (c == 3) ? 1'b0 : 1'b1, 1, 0);
    // split completion: D acks cycle 1, I acks cycle 4
    cyc(0, 0, 0, 0, 1, 1, 0);
    for (int c = 0; c < 5; c++)
      cyc(1, 1, 1, 1, (c == 4) ? 1'b0 : 1'b1, (c == 1) ? 1'b0 : 1'b1, 0);
    // D timeout, then error clear
    cyc(0, 0, 0, 0, 1, 1, 0);
    for (int c = 0; c < 8; c++) cyc(1, 0, 1, 0, 1, 1, 0);
    cyc(1, 0, 0, 0, 1, 1, 0);
    cyc(1, 0, 0, 0, 1, 1, 1);
    cyc(1, 0, 0, 0, 1, 1, 0);
    // dual timeout
    cyc(0, 0, 0, 0, 1, 1, 0);
    for (int c = 0; c < 8; c++) cyc(1, 1, 1, 0, 1, 1, 0);
    cyc(1, 0, 0, 0, 1, 1, 0);
    // timeout coinciding with err_clr
    cyc(0, 0, 0, 0, 1, 1, 0);
    for (int c = 0; c < 8; c++) cyc(1, 0, 1, 1, 1, 1, (c == 7) ? 1'b1 : 1'b0);
    cyc(1, 0, 0, 0, 1, 1, 0);
    // reset in the middle of a D wait
    cyc(0, 0, 0, 0, 1, 1, 0);
    cyc(1, 0, 1, 0, 1, 1, 0);
    cyc(1, 0, 1, 0, 1, 1, 0);
    cyc(0, 0, 1, 0, 1, 1, 0);
    cyc(1, 0, 1, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 1, 1, 0);
    // randomized traffic with varying acknowledge latency
    ack_pct = 90;
    ir = 0; mr = 0; mw = 0;
    for (int n = 0; n < 3000; n++) begin
      if (n % 50 == 0) begin
        case ($urandom_range(0, 2))
          0:       ack_pct = 90;
          1:       ack_pct = 40;
          default: ack_pct = 8;
        endcase
      end
      if (!m_frz_prev) begin
        ir = ($urandom_range(0, 99) < 70);
        mr = ($urandom_range(0, 99) < 50);
        mw = $urandom_range(0, 1) == 1;
      end
      cyc(($urandom_range(0, 199) != 0),
          ir, mr, mw,
          !($urandom_range(0, 99) < ack_pct),
          !($urandom_range(0, 99) < ack_pct),
          ($urandom_range(0, 99) < 5));
    end
    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_ctrl.md
Name: mem_bus_ctrl

Overview:
- Sequences the instruction-fetch and data-memory handshakes of the 5-stage pipeline core against external memories that acknowledge with ACKI_n/ACKD_n (active low).
- Drives MREQ/WRITE and holds the whole pipeline with a global freeze (PC and all pipe registers) until every outstanding access in the current cycle has completed.
- Times out hung accesses and reports a sticky bus error.
- Also counts freeze cycles for performance monitoring.

Parameters:
TIMEOUT, 8, wait cycles on one side before the access is forced complete with error (>=2)
CW, 4, width of each per-side wait counter (2^CW >= TIMEOUT)
SW, 16, width of the freeze-cycle statistics counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active low
if_req  in  1  IF stage presents a valid fetch address this cycle
mem_req  in  1  MEM stage holds a load or store (mem_read|mem_write)
mem_wr  in  1  MEM access is a store
ACKI_n  in  1  instruction memory acknowledge, active low
ACKD_n  in  1  data memory acknowledge, active low
err_clr  in  1  clears bus_err/err_src
MREQ  out  1  data memory request
WRITE  out  1  data write enable
freeze  out  1  hold PC and all pipeline registers
inst_valid  out  1  IDT valid to capture into IF/ID this cycle
data_done  out  1  pulse: data access retired on the advance cycle
bus_err  out  1  sticky timeout flag
err_src  out  2  sticky: bit0 I-side timed out, bit1 D-side timed out
stall_cnt  out  SW  saturating count of freeze cycles

Behaviour:
- While rst is low, all registers clear immediately: i_done, d_done, i_cnt, d_cnt, bus_err, err_src, stall_cnt. MREQ, WRITE, freeze, inst_valid and data_done are forced 0.
- Per side x (I/D), same structure:
  - pend_x = req_x & ~x_done.
  - ack_x = pend_x & ~ACK_n.
  - to_x = pend_x & ACK_n & (x_cnt == TIMEOUT-1).
  - ok_x = ~req_x | x_done | ack_x | to_x.
- freeze = ~(ok_I & ok_D), combinational. Zero-wait acks never freeze.
- Advance cycle = any cycle with freeze=0. On the advance cycle:
  - i_done and d_done clear.
  - data_done = mem_req.
  - inst_valid = if_req & (ack_I | i_done).
- inst_valid is also asserted in the cycle ack_I occurs while freeze=1, so IF/ID captures IDT then.
- x_done sets on ack_x or to_x when freeze=1 (the other side is still pending). It holds until the advance cycle.
- x_cnt:
  - Increments each cycle pend_x & ACK_n & ~to_x.
  - Clears on ack_x, to_x, advance, or ~req_x.
  - Never wraps.
- Timeout: to_x sets bus_err=1 and err_src[x]=1 (OR-accumulates). The access is treated as complete (data undefined).
- err_clr clears bus_err and err_src next edge. A timeout in the same cycle as err_clr wins (flag set).
- MREQ = mem_req & ~d_done & rst. It drops once the D-side acks, even while still frozen on I.
- WRITE = MREQ & mem_wr.
- stall_cnt increments on each freeze=1 cycle and saturates at 2^SW-1.
- Request inputs must stay stable while freeze=1. This is a bench assertion, not checked in RTL.
- Reset mid-wait abandons the access. The first post-reset cycle starts fresh.

Test Plan:
- Zero-wait, TIMEOUT=8: if_req=1, mem_req=1, mem_wr=0, ACKI_n=0, ACKD_n=0 in cycle 0 -> freeze=0, inst_valid=1, data_done=1, MREQ=1, WRITE=0, stall_cnt=0.
- I-wait: if_req=1, ACKI_n high cycles 0-2, low cycle 3 -> freeze=1 cycles 0-2, 0 in cycle 3, inst_valid=1 only in cycle 3, stall_cnt=3.
- Split completion: if_req=1, mem_req=1, mem_wr=1, ACKD_n low cycle 1, ACKI_n low cycle 4:
  - MREQ=WRITE=1 in cycles 0-1, 0 in cycles 2-3.
  - freeze=1 in cycles 0-3.
  - Cycle 4: advance, data_done=1.
  - stall_cnt=4.
- D timeout: mem_req=1, ACKD_n held high, TIMEOUT=8:
  - freeze=1 in cycles 0-6, 0 in cycle 7.
  - bus_err=1 and err_src=2'b10 from cycle 8.
  - err_clr pulse -> both 0 next edge.
- Dual timeout: both sides requested, neither acks -> release in cycle 7, err_src=2'b11, stall_cnt=7.
- Reset mid-wait: rst low in cycle 2 of a D wait -> MREQ, freeze, d_cnt, stall_cnt are 0 immediately. After rst is released and ACKD_n=0, the access completes zero-wait with bus_err=0.
